// File: rtl/fp_mult_normalizer_pipe_if.sv
// Handshake and data bundle between the multiplier front end, the normalizer and the packer.
// The member names match the original ports so that existing connections map across unchanged.
interface fp_mult_normalizer_pipe_if #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23
);
  logic                            valid_in;
  logic                            ready_out;
  logic                            sign_in;
  logic [EXP_WIDTH+1:0]            expoent_in;
  logic [2*(MANTISSA_WIDTH+1)-1:0] result_in;
  logic                            carry_in;
  logic                            valid_out;
  logic                            ready_in;
  logic                            sign_out;
  logic [EXP_WIDTH-1:0]            normal_e_out;
  logic [MANTISSA_WIDTH:0]         normal_m_out;
  logic                            overflow_out;
  logic                            underflow_out;
  logic                            inexact_out;

  modport master (
    output valid_in, sign_in, expoent_in, result_in, carry_in, ready_in,
    input  ready_out, valid_out, sign_out, normal_e_out, normal_m_out,
           overflow_out, underflow_out, inexact_out
  );

  modport slave (
    input  valid_in, sign_in, expoent_in, result_in, carry_in, ready_in,
    output ready_out, valid_out, sign_out, normal_e_out, normal_m_out,
           overflow_out, underflow_out, inexact_out
  );
endinterface

// File: rtl/fp_mult_normalizer_pipe.sv
// Two-stage normalizer for the FP multiplier: stage 1 normalizes the raw product, stage 2
// rounds to nearest-even and classifies the result as zero, overflow, underflow or normal.
module fp_mult_normalizer_pipe #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input logic                     clk_in,
  input logic                     rst_n_in,
  fp_mult_normalizer_pipe_if.slave bus
);
  localparam int W  = 2 * (MANTISSA_WIDTH + 1);
  localparam int XW = EXP_WIDTH + 3;
  localparam logic signed [XW-1:0] EXP_MAX = {3'b000, {EXP_WIDTH{1'b1}}};

  logic                       r_s1_valid, r_s1_sign, r_s1_zero, r_s1_carry;
  logic                       r_s1_guard, r_s1_sticky;
  logic [MANTISSA_WIDTH:0]    r_s1_mant;
  logic signed [XW-1:0]       r_s1_exp;

  logic                       r_s2_valid, r_sign, r_of, r_uf, r_inx;
  logic [EXP_WIDTH-1:0]       r_e;
  logic [MANTISSA_WIDTH:0]    r_m;

  logic                       w_ready, w_s2_en;
  logic                       w_n_guard, w_n_sticky;
  logic [MANTISSA_WIDTH:0]    w_n_mant;
  logic signed [XW-1:0]       w_exp_ext, w_n_exp;

  logic                       w_rnd_up;
  logic [MANTISSA_WIDTH+1:0]  w_rnd_sum;
  logic [MANTISSA_WIDTH:0]    w_fin_mant;
  logic signed [XW-1:0]       w_fin_exp;
  logic [EXP_WIDTH-1:0]       w_o_e;
  logic [MANTISSA_WIDTH:0]    w_o_m;
  logic                       w_o_of, w_o_uf, w_o_inx;

  // Stage 1 may take a beat when it is empty even if stage 2 is stalled.
  assign w_ready = !r_s2_valid || bus.ready_in || !r_s1_valid;
  assign w_s2_en = !r_s2_valid || bus.ready_in;

  always_comb begin
    w_exp_ext = {bus.expoent_in[EXP_WIDTH+1], bus.expoent_in};
    if (bus.result_in[W-1]) begin
      w_n_mant   = bus.result_in[W-1 -: MANTISSA_WIDTH+1];
      w_n_guard  = bus.result_in[W-2-MANTISSA_WIDTH];
      w_n_sticky = |bus.result_in[W-3-MANTISSA_WIDTH:0];
      w_n_exp    = w_exp_ext + XW'(1);
    end else begin
      w_n_mant   = bus.result_in[W-2 -: MANTISSA_WIDTH+1];
      w_n_guard  = bus.result_in[W-3-MANTISSA_WIDTH];
      w_n_sticky = |bus.result_in[W-4-MANTISSA_WIDTH:0];
      w_n_exp    = w_exp_ext;
    end
  end

  always_comb begin
    w_rnd_up  = r_s1_guard && (r_s1_sticky || r_s1_mant[0]);
    w_rnd_sum = {1'b0, r_s1_mant} + {{(MANTISSA_WIDTH+1){1'b0}}, w_rnd_up};
    if (w_rnd_sum[MANTISSA_WIDTH+1]) begin
      w_fin_mant = {1'b1, {MANTISSA_WIDTH{1'b0}}};
      w_fin_exp  = r_s1_exp + XW'(1);
    end else begin
      w_fin_mant = w_rnd_sum[MANTISSA_WIDTH:0];
      w_fin_exp  = r_s1_exp;
    end

    w_o_e   = '0;
    w_o_m   = '0;
    w_o_of  = 1'b0;
    w_o_uf  = 1'b0;
    w_o_inx = 1'b0;
    if (r_s1_zero) begin
      w_o_inx = 1'b0;
    end else if (r_s1_carry || (w_fin_exp >= EXP_MAX)) begin
      w_o_e   = '1;
      w_o_of  = 1'b1;
      w_o_inx = 1'b1;
    end else if (w_fin_exp[XW-1] || (w_fin_exp == '0)) begin
      w_o_uf  = 1'b1;
      w_o_inx = 1'b1;
    end else begin
      w_o_e   = w_fin_exp[EXP_WIDTH-1:0];
      w_o_m   = w_fin_mant;
      w_o_inx = r_s1_guard || r_s1_sticky;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_zero   <= 1'b0;
      r_s1_carry  <= 1'b0;
      r_s1_guard  <= 1'b0;
      r_s1_sticky <= 1'b0;
      r_s1_mant   <= '0;
      r_s1_exp    <= '0;
    end else if (w_ready) begin
      r_s1_valid <= bus.valid_in;
      if (bus.valid_in) begin
        r_s1_sign   <= bus.sign_in;
        r_s1_zero   <= (bus.result_in == '0);
        r_s1_carry  <= bus.carry_in;
        r_s1_guard  <= w_n_guard;
        r_s1_sticky <= w_n_sticky;
        r_s1_mant   <= w_n_mant;
        r_s1_exp    <= w_n_exp;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_s2_valid <= 1'b0;
      r_sign     <= 1'b0;
      r_e        <= '0;
      r_m        <= '0;
      r_of       <= 1'b0;
      r_uf       <= 1'b0;
      r_inx      <= 1'b0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sign <= r_s1_sign;
        r_e    <= w_o_e;
        r_m    <= w_o_m;
        r_of   <= w_o_of;
        r_uf   <= w_o_uf;
        r_inx  <= w_o_inx;
      end
    end
  end

  assign bus.ready_out     = w_ready;
  assign bus.valid_out     = r_s2_valid;
  assign bus.sign_out      = r_sign;
  assign bus.normal_e_out  = r_e;
  assign bus.normal_m_out  = r_m;
  assign bus.overflow_out  = r_of;
  assign bus.underflow_out = r_uf;
  assign bus.inexact_out   = r_inx;
endmodule

// File: tb/tb_fp_mult_normalizer_pipe.sv
// Scoreboard bench for fp_mult_normalizer_pipe: expected beats come from an independent
// rounding model, are queued on acceptance and compared when the DUT presents them.
module tb_fp_mult_normalizer_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_mult_normalizer_pipe_if #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23)) bus ();

  fp_mult_normalizer_pipe #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23)) u_dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  typedef struct packed {
    logic [35:0] val;
    logic [31:0] cyc;
    logic        lat;
  } exp_t;

  exp_t        q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned n_rdy_low = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Result packed as {sign, exp[7:0], mant[23:0], overflow, underflow, inexact}.
  function automatic logic [35:0] model(input logic s, input logic [9:0] e,
                                        input logic [47:0] p, input logic c);
    longint unsigned pp, mant, rem, half;
    int sh, ex;
    pp = {16'h0, p};
    if (p == 48'h0) return {s, 35'h0};
    sh   = p[47] ? 24 : 23;
    ex   = int'($signed(e)) + (p[47] ? 1 : 0);
    mant = pp >> sh;
    rem  = pp - (mant << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && mant[0])) mant++;
    if (mant == (64'd1 << 24)) begin
      mant = mant >> 1;
      ex++;
    end
    if (c || ex >= 255) return {s, 8'hFF, 24'h0, 3'b101};
    if (ex <= 0)        return {s, 8'h00, 24'h0, 3'b011};
    return {s, ex[7:0], mant[23:0], 2'b00, rem != 0};
  endfunction

  function automatic logic [35:0] dut_out();
    return {bus.sign_out, bus.normal_e_out, bus.normal_m_out,
            bus.overflow_out, bus.underflow_out, bus.inexact_out};
  endfunction

  task automatic step(input logic v, input logic s, input logic [9:0] e, input logic [47:0] p,
                      input logic c, input logic rdy, input logic lat);
    exp_t ent;
    @(negedge clk);
    bus.valid_in   = v;
    bus.sign_in    = s;
    bus.expoent_in = e;
    bus.result_in  = p;
    bus.carry_in   = c;
    bus.ready_in   = rdy;
    #1;
    if (bus.valid_out) begin
      if (q.size() == 0) check_eq("spurious_beat", 64'(dut_out()), 64'h0);
      else begin
        check_eq("beat", 64'(dut_out()), 64'(q[0].val));
        if (rdy) begin
          if (q[0].lat) check_eq("latency", 64'(cyc - q[0].cyc), 64'd2);
          void'(q.pop_front());
        end
      end
    end
    if (v && bus.ready_out) begin
      ent.val = model(s, e, p, c);
      ent.cyc = cyc;
      ent.lat = lat;
      q.push_back(ent);
    end
    if (!bus.ready_out) n_rdy_low++;
    cyc++;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 10'h0, 48'h0, 1'b0, rdy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1'b1);
    check_eq("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {27'h0, bus.valid_out, dut_out()}, 64'h0);
  endtask

  typedef struct {
    logic        s;
    logic [9:0]  e;
    logic [47:0] p;
    logic        c;
  } vec_t;

  vec_t vecs[$];
  logic [23:0] a, b;

  initial begin
    bus.valid_in = 1'b0; bus.sign_in = 1'b0; bus.expoent_in = '0;
    bus.result_in = '0;  bus.carry_in = 1'b0; bus.ready_in = 1'b0;

    #1;
    check_all_zero("reset_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("ready_after_reset", 64'(bus.ready_out), 64'd1);

    vecs.push_back('{1'b0, 10'd127, 48'h9000_0000_0000, 1'b0});
    vecs.push_back('{1'b0, 10'd100, {2'b01, 23'h7FFFFF, 1'b1, 22'h0}, 1'b0});
    vecs.push_back('{1'b1, 10'd100, {2'b01, 23'h000000, 1'b1, 22'h0}, 1'b0});
    vecs.push_back('{1'b0, 10'd254, 48'h8000_0000_0000, 1'b0});
    vecs.push_back('{1'b0, 10'd0,   48'h4000_0000_0000, 1'b0});
    vecs.push_back('{1'b1, 10'd0,   48'h0, 1'b0});
    vecs.push_back('{1'b0, 10'd100, 48'h9000_0000_0000, 1'b1});
    vecs.push_back('{1'b0, 10'd253, 48'h8000_0000_0000, 1'b0});
    vecs.push_back('{1'b0, 10'd1,   48'h4000_0000_0000, 1'b0});
    vecs.push_back('{1'b0, 10'h3F6, 48'hC000_0000_0000, 1'b0});
    vecs.push_back('{1'b0, 10'd253, {2'b01, 23'h7FFFFF, 1'b1, 22'h1}, 1'b0});
    vecs.push_back('{1'b0, 10'd50,  {1'b1, 23'h123456, 1'b1, 23'h0}, 1'b0});
    vecs.push_back('{1'b0, 10'd50,  {1'b1, 23'h123457, 1'b1, 23'h0}, 1'b0});
    foreach (vecs[i]) step(1'b1, vecs[i].s, vecs[i].e, vecs[i].p, vecs[i].c, 1'b1, 1'b1);
    drain();

    for (int i = 0; i < 60; i++) begin
      a = 24'($urandom_range(24'h800000, 24'hFFFFFF));
      b = 24'($urandom_range(24'h800000, 24'hFFFFFF));
      step($urandom_range(0, 3) != 0, 1'($urandom), 10'($urandom_range(0, 300) - 20),
           48'(a) * 48'(b), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 1'b0);
    end
    drain();

    n_rdy_low = 0;
    begin
      int sent = 0;
      for (int k = 0; k < 30 && (sent < 6 || q.size() > 0); k++) begin
        logic rdy;
        rdy = !(k >= 3 && k <= 5);
        a = 24'h800000 + 24'(k * 24'h011111);
        if (sent < 6) begin
          step(1'b1, 1'b0, 10'(100 + sent), 48'(a) * 48'hC00000, 1'b0, rdy, 1'b0);
          if (q.size() > 0 && q[q.size()-1].cyc == cyc - 1) sent++;
        end else idle(rdy);
      end
      check_eq("bp_all_sent", 64'(sent), 64'd6);
      check_eq("bp_ready_dropped", 64'(n_rdy_low > 0), 64'd1);
    end
    drain();

    step(1'b1, 1'b0, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 10'd120, 48'hA000_0000_0000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus.valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("midstream_reset");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 10'd127, 48'hB000_0000_0000, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    check_eq("no_early_output", 64'(bus.valid_out), 64'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
